game_sequencer: RTL and testbench

Central play-state controller for the Flappy VGA game. It turns raw button levels into one-cycle commands and sequences the game phases IDLE → READY → PLAY → DYING → OVER. It drives the start/ack/stop handshakes of the pipe X-position RAM, flight physics and obstacle logic, generates the loss-flash signal for the VGA colour path, and keeps a high score for the seven-segment display.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_sequencer_edge_pulse.sv | 28 ++
 rtl/game_sequencer.sv | 174 +++++++++++++++++
 tb/tb_game_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Flappy VGA play-state controller.
// Holds the state encodings, the state enum built on them and the
// default sizing used by game_sequencer.
package game_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_DYING = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int unsigned SCORE_W_DEF     = 4;
    localparam int unsigned READY_TICKS_DEF = 8;
    localparam int unsigned FLASH_TICKS_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_READY = ST_READY,
        S_PLAY  = ST_PLAY,
        S_DYING = ST_DYING,
        S_OVER  = ST_OVER
    } state_t;

endpackage

// File: rtl/game_sequencer_edge_pulse.sv
// Rising-edge detector for an already-synchronised button level.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; history loads 1 so a button held
//           through reset does not register as a press
//   level - button level
//   rise  - high for the cycle in which level is 1 and the stored
//           previous level is 0 (combinational from the history register)
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Play-state controller: IDLE -> READY -> PLAY -> DYING -> OVER.
// Turns button levels into one-cycle commands, drives the start/ack/stop
// handshakes for pipes, physics and obstacle logic, generates the loss
// flash and keeps the high score.
// Ports:
//   Clk, reset           - clock, synchronous active-high reset
//   tick                 - one-cycle frame strobe
//   btn_start, btn_jump  - synchronised button levels
//   collide              - bird/pipe overlap level
//   score                - current score from the pipe RAM
//   start_pulse, ack_pulse, jump_pulse - registered one-cycle commands
//   run, stop            - motion enable / game-ended level
//   flash                - loss-flash enable for the colour path
//   high_score, new_best - best score since reset, last game beat it
//   state                - current state encoding
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned READY_TICKS = READY_TICKS_DEF,
    parameter int unsigned FLASH_TICKS = FLASH_TICKS_DEF,
    parameter int unsigned SCORE_W     = SCORE_W_DEF
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               btn_start,
    input  logic               btn_jump,
    input  logic               collide,
    input  logic [SCORE_W-1:0] score,
    output logic               start_pulse,
    output logic               ack_pulse,
    output logic               run,
    output logic               stop,
    output logic               jump_pulse,
    output logic               flash,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_best,
    output logic [2:0]         state
);

    localparam int unsigned CNT_MAX = (READY_TICKS > FLASH_TICKS) ? READY_TICKS : FLASH_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_d, ack_d, jump_d, run_d, stop_d, flash_d, best_d;
    logic [SCORE_W-1:0] high_d;
    logic               start_edge, jump_edge;

    edge_pulse u_start_edge (
        .clk   (Clk),
        .reset (reset),
        .level (btn_start),
        .rise  (start_edge)
    );

    edge_pulse u_jump_edge (
        .clk   (Clk),
        .reset (reset),
        .level (btn_jump),
        .rise  (jump_edge)
    );

    // A tick coinciding with entry into READY or DYING is the first tick
    // of that state, so the counter starts at 1 (and DYING's flash is
    // already toggled); every other transition starts the counter at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        ack_d   = 1'b0;
        jump_d  = 1'b0;
        flash_d = flash;
        high_d  = high_score;
        best_d  = new_best;

        case (state_q)
            S_IDLE: begin
                flash_d = 1'b0;
                if (start_edge) begin
                    start_d = 1'b1;
                    state_d = S_READY;
                    cnt_d   = tick ? CNT_W'(1) : '0;
                end
            end
            S_READY: begin
                if (jump_edge) begin
                    state_d = S_PLAY;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_W'(READY_TICKS - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (collide) begin
                    state_d = S_DYING;
                    cnt_d   = tick ? CNT_W'(1) : '0;
                    flash_d = tick;
                    if (score > high_score) begin
                        high_d = score;
                        best_d = 1'b1;
                    end
                end else if (jump_edge) begin
                    jump_d = 1'b1;
                end
            end
            S_DYING: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(FLASH_TICKS - 1)) begin
                        state_d = S_OVER;
                        cnt_d   = '0;
                        flash_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        flash_d = ~flash;
                    end
                end
            end
            S_OVER: begin
                flash_d = 1'b0;
                if (start_edge) begin
                    ack_d   = 1'b1;
                    best_d  = 1'b0;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                flash_d = 1'b0;
                high_d  = '0;
                best_d  = 1'b0;
            end
        endcase

        run_d  = (state_d == S_PLAY);
        stop_d = (state_d == S_DYING) || (state_d == S_OVER);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start_pulse <= 1'b0;
            ack_pulse   <= 1'b0;
            jump_pulse  <= 1'b0;
            run         <= 1'b0;
            stop        <= 1'b0;
            flash       <= 1'b0;
            high_score  <= '0;
            new_best    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_pulse <= start_d;
            ack_pulse   <= ack_d;
            jump_pulse  <= jump_d;
            run         <= run_d;
            stop        <= stop_d;
            flash       <= flash_d;
            high_score  <= high_d;
            new_best    <= best_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int unsigned READY_TICKS = 8;
    localparam int unsigned FLASH_TICKS = 16;
    localparam int unsigned SCORE_W     = 4;

    logic               Clk;
    logic               reset;
    logic               tick;
    logic               btn_start;
    logic               btn_jump;
    logic               collide;
    logic [SCORE_W-1:0] score;
    logic               start_pulse;
    logic               ack_pulse;
    logic               run;
    logic               stop;
    logic               jump_pulse;
    logic               flash;
    logic [SCORE_W-1:0] high_score;
    logic               new_best;
    logic [2:0]         state;

    game_sequencer #(
        .READY_TICKS (READY_TICKS),
        .FLASH_TICKS (FLASH_TICKS),
        .SCORE_W     (SCORE_W)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .tick        (tick),
        .btn_start   (btn_start),
        .btn_jump    (btn_jump),
        .collide     (collide),
        .score       (score),
        .start_pulse (start_pulse),
        .ack_pulse   (ack_pulse),
        .run         (run),
        .stop        (stop),
        .jump_pulse  (jump_pulse),
        .flash       (flash),
        .high_score  (high_score),
        .new_best    (new_best),
        .state       (state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: phase number (0 IDLE .. 4 OVER), ticks seen in the
    // current timed phase, last button levels, and the expected outputs.
    int unsigned m_phase, m_ticks, m_hs;
    bit          m_nb, m_prev_s, m_prev_j;
    bit          e_start, e_ack, e_jump;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit se, je;
        se = btn_start && !m_prev_s;
        je = btn_jump && !m_prev_j;
        m_prev_s = reset ? 1'b1 : btn_start;
        m_prev_j = reset ? 1'b1 : btn_jump;
        e_start = 0;
        e_ack   = 0;
        e_jump  = 0;
        if (reset) begin
            m_phase = 0;
            m_ticks = 0;
            m_hs    = 0;
            m_nb    = 0;
        end else begin
            case (m_phase)
                0: if (se) begin
                    e_start = 1;
                    m_phase = 1;
                    m_ticks = tick ? 1 : 0;
                end
                1: begin
                    if (tick) m_ticks++;
                    if (je || m_ticks == READY_TICKS) begin
                        m_phase = 2;
                        m_ticks = 0;
                    end
                end
                2: begin
                    if (collide) begin
                        m_phase = 3;
                        m_ticks = tick ? 1 : 0;
                        if (int'(score) > m_hs) begin
                            m_hs = score;
                            m_nb = 1;
                        end
                    end else if (je) begin
                        e_jump = 1;
                    end
                end
                3: begin
                    if (tick) m_ticks++;
                    if (m_ticks == FLASH_TICKS) begin
                        m_phase = 4;
                        m_ticks = 0;
                    end
                end
                default: if (se) begin
                    e_ack   = 1;
                    m_nb    = 0;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("state", state, m_phase);
        check("start_pulse", start_pulse, e_start);
        check("ack_pulse", ack_pulse, e_ack);
        check("jump_pulse", jump_pulse, e_jump);
        check("run", run, m_phase == 2);
        check("stop", stop, m_phase >= 3);
        check("flash", flash, (m_phase == 3) ? m_ticks % 2 : 0);
        check("high_score", high_score, m_hs);
        check("new_best", new_best, m_nb);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b0;
        cycle();
        btn_start = 1'b1;
        cycle();
    endtask

    task automatic press_jump();
        btn_jump = 1'b0;
        cycle();
        btn_jump = 1'b1;
        cycle();
    endtask

    task automatic dying_to_over();
        int unsigned toggles;
        logic        pf;
        toggles = 0;
        pf = flash;
        for (int k = 0; k < int'(FLASH_TICKS); k++) begin
            do_tick();
            if (flash !== pf) toggles++;
            pf = flash;
            cycle();
        end
        check("flash_toggles", toggles, FLASH_TICKS);
        check("over_state", state, 4);
        check("over_flash", flash, 0);
    endtask

    initial begin
        int unsigned jp;
        reset = 1'b1; tick = 1'b0; btn_start = 1'b1; btn_jump = 1'b0;
        collide = 1'b0; score = '0;
        m_phase = 0; m_ticks = 0; m_hs = 0; m_nb = 0;
        m_prev_s = 1; m_prev_j = 1;

        // Reset with start held, then release reset: no start command.
        repeat (3) cycle();
        check("reset_state", state, 0);
        reset = 1'b0;
        repeat (3) cycle();
        check("held_start_no_pulse", start_pulse, 0);
        press_start();
        check("start_pulse", start_pulse, 1);
        check("start_to_ready", state, 1);
        cycle();
        check("start_pulse_one_cycle", start_pulse, 0);

        // READY auto-start after 8 ticks.
        for (int k = 0; k < int'(READY_TICKS) - 1; k++) begin
            do_tick();
            cycle();
        end
        check("ready_before_last_tick", state, 1);
        do_tick();
        check("auto_play_state", state, 2);
        check("auto_play_run", run, 1);
        check("auto_play_no_jump", jump_pulse, 0);

        // Jump edges three cycles apart, then a held button.
        for (int k = 0; k < 3; k++) begin
            btn_jump = 1'b1;
            cycle();
            check("jump_edge_pulse", jump_pulse, 1);
            btn_jump = 1'b0;
            cycle();
            check("jump_pulse_end", jump_pulse, 0);
            cycle();
        end
        jp = 0;
        btn_jump = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            jp += jump_pulse;
        end
        check("held_jump_pulses", jp, 1);
        btn_jump = 1'b0;
        cycle();

        // Collide together with a jump edge: collide wins.
        score = 4'd5;
        btn_jump = 1'b1;
        collide = 1'b1;
        cycle();
        collide = 1'b0;
        check("collide_no_jump", jump_pulse, 0);
        check("dying_state", state, 3);
        check("dying_run", run, 0);
        check("dying_stop", stop, 1);
        check("first_high_score", high_score, 5);
        check("first_new_best", new_best, 1);

        // Start edge in DYING is ignored.
        press_start();
        check("dying_ignores_start", state, 3);
        check("dying_no_ack", ack_pulse, 0);
        dying_to_over();
        press_start();
        check("over_ack", ack_pulse, 1);
        check("ack_to_idle", state, 0);
        check("ack_clears_best", new_best, 0);
        check("ack_keeps_high", high_score, 5);

        // Second game: jump edge after 2 READY ticks, equal score ending.
        press_start();
        do_tick(); cycle();
        do_tick(); cycle();
        press_jump();
        check("ready_jump_play", state, 2);
        check("ready_jump_no_pulse", jump_pulse, 0);
        collide = 1'b1;
        cycle();
        collide = 1'b0;
        check("equal_score_high", high_score, 5);
        check("equal_score_no_best", new_best, 0);
        dying_to_over();
        press_start();

        // Third game: reset in PLAY coinciding with collide.
        press_start();
        press_jump();
        check("third_game_play", state, 2);
        reset = 1'b1;
        collide = 1'b1;
        cycle();
        reset = 1'b0;
        collide = 1'b0;
        check("mid_reset_state", state, 0);
        check("mid_reset_high", high_score, 0);
        check("mid_reset_run", run, 0);
        check("mid_reset_stop", stop, 0);
        check("mid_reset_jump", jump_pulse, 0);

        // Randomised play against the model.
        for (int i = 0; i < 3000; i++) begin
            tick = !tick && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) btn_start = !btn_start;
            if ($urandom_range(0, 4) == 0) btn_jump = !btn_jump;
            collide = ($urandom_range(0, 11) == 0);
            score = SCORE_W'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
